// File: rtl/ram_pkg.sv
// Shared types for the two-requester RAM arbiter.
package ram_pkg;

    localparam int NUM_REQ = 2;

    // Arbiter FSM states.
    typedef enum logic {
        INIT  = 1'b0,
        SERVE = 1'b1
    } arb_state_t;

    // Requester identifier (0 or 1).
    typedef logic req_id_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Read tag shift register: carries {valid, requester id} for each read from
// its grant cycle to the cycle its RAM data appears, RD_LATENCY stages deep.
import ram_pkg::*;

module rd_tag_pipe #(
    parameter int RD_LATENCY = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    i_valid,
    input  req_id_t i_id,
    output logic    o_valid,
    output req_id_t o_id
);

    logic [RD_LATENCY-1:0] r_valid;
    req_id_t               r_id [RD_LATENCY];

    // Advance every tag one stage per cycle; reset drops all in-flight reads.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_id[i] <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_id[0]    <= i_id;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_id[i]    <= r_id[i-1];
            end
        end
    end

    assign o_valid = r_valid[RD_LATENCY-1];
    assign o_id    = r_id[RD_LATENCY-1];

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter giving two requesters access to one single-port RAM.
// Build macro RAM_ARBITER_INIT_EN: when defined, the RAM is swept to zero
// (one word per cycle) after every reset before requests are accepted.
//
// state | meaning
// INIT  | zero-fill sweep in progress, no grants, busy high
// SERVE | arbitrating requests, one grant per cycle at most
import ram_pkg::*;

module ram_arbiter #(
    parameter int MEM_WIDTH  = 16,
    parameter int MEM_DEPTH  = 1024,
    parameter int ADDR_SIZE  = 10,
    parameter int RD_LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               req,
    input  logic [1:0]               we,
    input  logic [2*ADDR_SIZE-1:0]   addr,
    input  logic [2*MEM_WIDTH-1:0]   wdata,
    output logic [1:0]               gnt,
    output logic [1:0]               rvalid,
    output logic [MEM_WIDTH-1:0]     rdata,
    output logic                     busy,
    output logic [MEM_WIDTH-1:0]     ram_din,
    output logic [ADDR_SIZE-1:0]     ram_addr,
    output logic                     ram_wr_en,
    output logic                     ram_rd_en,
    output logic                     ram_blk_select,
    output logic                     ram_addr_en,
    output logic                     ram_dout_en,
    input  logic [MEM_WIDTH-1:0]     ram_dout
);

    arb_state_t             w_state;
    logic                   w_init_wr;
    logic [ADDR_SIZE-1:0]   w_init_addr;
    logic [1:0]             w_gnt;
    logic                   w_any;
    req_id_t                w_gnt_id;
    req_id_t                r_last;
    logic                   w_tag_valid;
    req_id_t                w_tag_id;

`ifdef RAM_ARBITER_INIT_EN
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

    arb_state_t             r_state;
    logic [ADDR_SIZE-1:0]   r_init_cnt;

    // Sweep counter walks 0..MEM_DEPTH-1, then hands over to SERVE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= INIT;
            r_init_cnt <= '0;
        end else if (r_state == INIT) begin
            r_init_cnt <= r_init_cnt + ADDR_SIZE'(1);
            if (r_init_cnt == LAST_ADDR) begin
                r_state <= SERVE;
            end
        end
    end

    assign w_state     = r_state;
    assign w_init_wr   = rst && (r_state == INIT);
    assign w_init_addr = r_init_cnt;
`else
    assign w_state     = SERVE;
    assign w_init_wr   = 1'b0;
    assign w_init_addr = '0;
`endif

    assign busy = (w_state == INIT);

    // Round-robin pick: on a tie the requester not granted last wins.
    always_comb begin
        w_gnt = 2'b00;
        if (rst && (w_state == SERVE)) begin
            if (req == 2'b11) begin
                w_gnt = r_last ? 2'b01 : 2'b10;
            end else begin
                w_gnt = req;
            end
        end
    end

    assign gnt      = w_gnt;
    assign w_any    = |w_gnt;
    assign w_gnt_id = w_gnt[1];

    // Remember the last winner; reset points at requester 1 so 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last <= 1'b1;
        end else if (w_any) begin
            r_last <= w_gnt_id;
        end
    end

    // RAM command mux: sweep write during INIT, granted slice during SERVE.
    always_comb begin
        ram_blk_select = 1'b0;
        ram_wr_en      = 1'b0;
        ram_rd_en      = 1'b0;
        ram_addr       = w_gnt_id ? addr[2*ADDR_SIZE-1:ADDR_SIZE] : addr[ADDR_SIZE-1:0];
        ram_din        = w_gnt_id ? wdata[2*MEM_WIDTH-1:MEM_WIDTH] : wdata[MEM_WIDTH-1:0];
        if (w_init_wr) begin
            ram_blk_select = 1'b1;
            ram_wr_en      = 1'b1;
            ram_addr       = w_init_addr;
            ram_din        = '0;
        end else if (w_any) begin
            ram_blk_select = 1'b1;
            ram_wr_en      = we[w_gnt_id];
            ram_rd_en      = ~we[w_gnt_id];
        end
    end

    assign ram_addr_en = 1'b1;
    assign ram_dout_en = 1'b1;

    rd_tag_pipe #(
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_any & ~we[w_gnt_id]),
        .i_id    (w_gnt_id),
        .o_valid (w_tag_valid),
        .o_id    (w_tag_id)
    );

    // Tags still in the pipe during reset are masked until the clearing edge.
    assign rvalid = (rst && w_tag_valid) ? (w_tag_id ? 2'b10 : 2'b01) : 2'b00;
    assign rdata  = ram_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: one DUT with RD_LATENCY=2 and one with RD_LATENCY=1
// share the same stimulus; each drives its own behavioural RAM.
module tb_ram_arbiter;

    localparam int MEM_WIDTH = 16;
    localparam int MEM_DEPTH = 1024;
    localparam int ADDR_SIZE = 10;
    localparam logic [15:0] FILL = 16'hDEAD;
`ifdef RAM_ARBITER_INIT_EN
    localparam int INIT_CYCLES = MEM_DEPTH;
`else
    localparam int INIT_CYCLES = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [19:0] addr;
    logic [31:0] wdata;

    logic [1:0]  gnt_l2, rvalid_l2, gnt_l1, rvalid_l1;
    logic [15:0] rdata_l2, rdata_l1, din_l2, din_l1, dout_l2, dout_l1;
    logic [9:0]  raddr_l2, raddr_l1;
    logic        busy_l2, busy_l1;
    logic        wr_l2, rd_l2, blk_l2, aen_l2, den_l2;
    logic        wr_l1, rd_l1, blk_l1, aen_l1, den_l1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.MEM_WIDTH(16), .MEM_DEPTH(1024), .ADDR_SIZE(10), .RD_LATENCY(2)) dut_l2 (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt_l2), .rvalid(rvalid_l2), .rdata(rdata_l2), .busy(busy_l2),
        .ram_din(din_l2), .ram_addr(raddr_l2), .ram_wr_en(wr_l2), .ram_rd_en(rd_l2),
        .ram_blk_select(blk_l2), .ram_addr_en(aen_l2), .ram_dout_en(den_l2), .ram_dout(dout_l2));

    ram_arbiter #(.MEM_WIDTH(16), .MEM_DEPTH(1024), .ADDR_SIZE(10), .RD_LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt_l1), .rvalid(rvalid_l1), .rdata(rdata_l1), .busy(busy_l1),
        .ram_din(din_l1), .ram_addr(raddr_l1), .ram_wr_en(wr_l1), .ram_rd_en(rd_l1),
        .ram_blk_select(blk_l1), .ram_addr_en(aen_l1), .ram_dout_en(den_l1), .ram_dout(dout_l1));

    // Behavioural single-port RAMs: read-before-write, 2-cycle and 1-cycle read.
    logic [15:0] mem2 [MEM_DEPTH];
    logic [15:0] mem1 [MEM_DEPTH];
    logic [15:0] rd2_s0, rd2_s1, rd1_s0;
    bit          ram_ready = 0;

    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem2[i] <= FILL;
                mem1[i] <= FILL;
            end
            ram_ready <= 1;
        end else begin
            if (blk_l2 && rd_l2) rd2_s0 <= mem2[raddr_l2];
            if (blk_l2 && wr_l2) mem2[raddr_l2] <= din_l2;
            if (blk_l1 && rd_l1) rd1_s0 <= mem1[raddr_l1];
            if (blk_l1 && wr_l1) mem1[raddr_l1] <= din_l1;
        end
        rd2_s1 <= rd2_s0;
    end
    assign dout_l2 = rd2_s1;
    assign dout_l1 = rd1_s0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        int          id;
        logic [15:0] data;
    } rd_exp_t;

    rd_exp_t     q1[$];
    rd_exp_t     q2[$];
    logic [15:0] m_mem [MEM_DEPTH];
    int          m_last = 1;
    int          m_init_left = 0;
    bit          m_live = 0;
    int          cyc = 0;

    always @(negedge clk) begin
        logic [1:0]  e_gnt, ev1, ev2;
        logic [15:0] ed1, ed2, e_din;
        logic [9:0]  e_addr;
        bit          e_init, e_blk, e_wr, e_rd;
        int          e_id;
        if (rst !== 1'b1) begin
            chk("rst_gnt_l2", gnt_l2, 0);     chk("rst_gnt_l1", gnt_l1, 0);
            chk("rst_rvalid_l2", rvalid_l2, 0); chk("rst_rvalid_l1", rvalid_l1, 0);
            chk("rst_en_l2", {blk_l2, wr_l2, rd_l2}, 0);
            chk("rst_en_l1", {blk_l1, wr_l1, rd_l1}, 0);
            if (!m_live) begin
                for (int i = 0; i < MEM_DEPTH; i++) m_mem[i] = FILL;
            end
            m_live = 1;
            m_last = 1;
            m_init_left = INIT_CYCLES;
            q1.delete();
            q2.delete();
        end else if (m_live) begin
            e_init = (m_init_left != 0);
            e_gnt  = 2'b00;
            if (!e_init) begin
                if (req == 2'b11) e_gnt = (m_last == 0) ? 2'b10 : 2'b01;
                else              e_gnt = req;
            end
            e_id   = e_gnt[1] ? 1 : 0;
            e_blk  = e_init || (e_gnt != 0);
            e_wr   = e_init || ((e_gnt != 0) && we[e_id]);
            e_rd   = (e_gnt != 0) && !we[e_id];
            e_addr = e_init ? 10'(MEM_DEPTH - m_init_left) : (e_id == 1 ? addr[19:10] : addr[9:0]);
            e_din  = e_init ? 16'h0 : (e_id == 1 ? wdata[31:16] : wdata[15:0]);
            ev1 = 2'b00; ed1 = '0; ev2 = 2'b00; ed2 = '0;
            if (q1.size() > 0 && q1[0].due == cyc) begin
                ev1 = (q1[0].id == 1) ? 2'b10 : 2'b01; ed1 = q1[0].data; void'(q1.pop_front());
            end
            if (q2.size() > 0 && q2[0].due == cyc) begin
                ev2 = (q2[0].id == 1) ? 2'b10 : 2'b01; ed2 = q2[0].data; void'(q2.pop_front());
            end
            chk("gnt_l2", gnt_l2, e_gnt);   chk("gnt_l1", gnt_l1, e_gnt);
            chk("busy_l2", busy_l2, e_init); chk("busy_l1", busy_l1, e_init);
            chk("en_l2", {blk_l2, wr_l2, rd_l2}, {e_blk, e_wr, e_rd});
            chk("en_l1", {blk_l1, wr_l1, rd_l1}, {e_blk, e_wr, e_rd});
            chk("tie_en", {aen_l2, den_l2, aen_l1, den_l1}, 4'hF);
            if (e_blk) begin
                chk("ram_addr_l2", raddr_l2, e_addr); chk("ram_addr_l1", raddr_l1, e_addr);
                chk("ram_din_l2", din_l2, e_din);     chk("ram_din_l1", din_l1, e_din);
            end
            chk("rvalid_l2", rvalid_l2, ev2); chk("rvalid_l1", rvalid_l1, ev1);
            if (ev2 != 0) chk("rdata_l2", rdata_l2, ed2);
            if (ev1 != 0) chk("rdata_l1", rdata_l1, ed1);
            if (e_init) begin
                m_mem[e_addr] = 16'h0;
                m_init_left--;
            end else if (e_gnt != 0) begin
                if (we[e_id]) m_mem[e_addr] = e_din;
                else begin
                    q1.push_back('{due: cyc + 1, id: e_id, data: m_mem[e_addr]});
                    q2.push_back('{due: cyc + 2, id: e_id, data: m_mem[e_addr]});
                end
                m_last = e_id;
            end
        end
        cyc++;
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string nm, input int exp_n);
        int  n = 0;
        bit  done = 0;
        for (int k = 0; k < 3000 && !done; k++) begin
            @(negedge clk);
            if (busy_l2 === 1'b0) done = 1;
            else n++;
            tick();
        end
        chk(nm, n, exp_n);
    endtask

    initial begin
        int nbad;
        rst = 1'b0; req = 2'b00; we = 2'b00; addr = '0; wdata = '0;
        repeat (3) tick();
        @(negedge clk);
        chk("reset_gnt", gnt_l2, 2'b00);
        chk("reset_rvalid", rvalid_l2, 2'b00);
        tick();

        // Release reset; sweep (if built) then idle.
        rst = 1'b1;
        wait_idle("init_busy_cycles", INIT_CYCLES);
        nbad = 0;
        for (int i = 0; i < MEM_DEPTH; i++) begin
            if (mem2[i] !== ((INIT_CYCLES != 0) ? 16'h0 : FILL)) nbad++;
        end
        chk("init_ram_content", nbad, 0);

        // Write 0xA5A5 to addr 5 from req0, read it back from req1.
        req = 2'b01; we = 2'b01; addr = {10'd0, 10'd5}; wdata = {16'h0, 16'hA5A5};
        @(negedge clk); chk("wr5_gnt", gnt_l2, 2'b01); tick();
        req = 2'b10; we = 2'b00; addr = {10'd5, 10'd0};
        @(negedge clk); chk("rd5_gnt", gnt_l2, 2'b10); tick();
        req = 2'b00;
        @(negedge clk);
        chk("rd5_l1_rvalid", rvalid_l1, 2'b10); chk("rd5_l1_rdata", rdata_l1, 16'hA5A5);
        chk("rd5_l2_not_yet", rvalid_l2, 2'b00);
        tick();
        @(negedge clk);
        chk("rd5_l2_rvalid", rvalid_l2, 2'b10); chk("rd5_l2_rdata", rdata_l2, 16'hA5A5);
        tick();

        // Read addr 7 then overwrite it the next cycle; read keeps old data.
        req = 2'b01; we = 2'b01; addr = {10'd0, 10'd7}; wdata = {16'h0, 16'h0F0F}; tick();
        req = 2'b10; we = 2'b00; addr = {10'd7, 10'd0}; tick();
        req = 2'b01; we = 2'b01; addr = {10'd0, 10'd7}; wdata = {16'h0, 16'h1234};
        @(negedge clk); chk("raw_l1_rdata", rdata_l1, 16'h0F0F); chk("raw_l1_rvalid", rvalid_l1, 2'b10); tick();
        req = 2'b00;
        @(negedge clk); chk("raw_l2_rdata", rdata_l2, 16'h0F0F); chk("raw_l2_rvalid", rvalid_l2, 2'b10); tick();
        req = 2'b10; we = 2'b00; addr = {10'd7, 10'd0}; tick();
        req = 2'b00;
        @(negedge clk); chk("rd7_new_l1", rdata_l1, 16'h1234); tick();
        @(negedge clk); chk("rd7_new_l2", rdata_l2, 16'h1234); tick();

        // Both requesters reading every cycle for 8 cycles.
        we = 2'b00; addr = {10'd7, 10'd5};
        for (int k = 0; k < 10; k++) begin
            req = (k < 8) ? 2'b11 : 2'b00;
            @(negedge clk);
            if (k < 8) chk("tie_gnt", gnt_l2, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k >= 2) chk("tie_l2_order", rvalid_l2, ((k - 2) % 2 == 0) ? 2'b01 : 2'b10);
            if (k >= 1 && k <= 8) chk("tie_l1_order", rvalid_l1, ((k - 1) % 2 == 0) ? 2'b01 : 2'b10);
            tick();
        end

        // Reset one cycle after a read grant drops that read.
        req = 2'b01; we = 2'b00; addr = {10'd0, 10'd5};
        @(negedge clk); chk("pre_rst_gnt", gnt_l2, 2'b01); tick();
        rst = 1'b0; req = 2'b00;
        @(negedge clk); chk("rst_drop_l1", rvalid_l1, 2'b00); chk("rst_drop_l2a", rvalid_l2, 2'b00); tick();
        rst = 1'b1;
        @(negedge clk); chk("rst_drop_l2b", rvalid_l2, 2'b00); tick();
        wait_idle("reinit_busy_cycles", (INIT_CYCLES == 0) ? 0 : INIT_CYCLES - 1);
        req = 2'b11; we = 2'b00; addr = {10'd7, 10'd5};
        @(negedge clk); chk("first_tie_after_rst", gnt_l2, 2'b01); tick();
        req = 2'b00;
        repeat (3) tick();

        // Mixed traffic, checked against the model.
        for (int k = 0; k < 24; k++) begin
            req   = 2'(k % 4);
            we    = 2'((k * 3) % 4);
            addr  = {10'((k * 11) % 8), 10'((k * 5) % 8)};
            wdata = {16'(k * 7 + 1), 16'(k * 16'h0101)};
            tick();
        end
        req = 2'b00;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter MEM_WIDTH, default 16, meaning data width of the shared RAM.
REQ-002 SHALL have parameter MEM_DEPTH, default 1024, meaning number of RAM words.
REQ-003 SHALL have parameter ADDR_SIZE, default 10, meaning RAM address width.
REQ-004 SHALL have parameter RD_LATENCY, default 2, meaning cycles from grant to RAM read data valid (2 = output pipeline on, 1 = off).
REQ-005 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port req  input  2  per-requester access request; bit i = requester i; held until granted.
REQ-008 SHALL have port we  input  2  per-requester access type: 1 = write, 0 = read.
REQ-009 SHALL have port addr  input  2*ADDR_SIZE  per-requester address; slice i = requester i.
REQ-010 SHALL have port wdata  input  2*MEM_WIDTH  per-requester write data.
REQ-011 SHALL have port gnt  output  2  one-hot grant, combinational, same cycle as req.
REQ-012 SHALL have port rvalid  output  2  read data valid for requester i, one cycle per read.
REQ-013 SHALL have port rdata  output  MEM_WIDTH  read data, shared, qualified by rvalid.
REQ-014 SHALL have port busy  output  1  high while not accepting requests.
REQ-015 SHALL have RAM-side ports: ram_din (MEM_WIDTH), ram_addr (ADDR_SIZE), ram_wr_en, ram_rd_en, ram_blk_select, ram_addr_en, ram_dout_en (all 1) as outputs, and ram_dout (MEM_WIDTH) as input.

Function
REQ-016 SHALL have FSM states INIT and SERVE; no grants in INIT; busy = (state==INIT).
REQ-017 SHALL grant in SERVE at most one requester per cycle, back-to-back grants allowed every cycle.
REQ-018 SHALL arbitrate round-robin: if both req, grant the requester not granted last; a lone requester is always granted.
REQ-019 SHALL drive in a grant cycle: ram_blk_select=1, ram_addr/ram_din from the granted slice, ram_wr_en=we[i], ram_rd_en=~we[i]; otherwise blk_select, wr_en and rd_en are 0.
REQ-020 SHALL tie ram_addr_en=1 and ram_dout_en=1.
REQ-021 SHALL track each read with a RD_LATENCY-deep tag shift register (valid + requester id), asserting rvalid[id] exactly RD_LATENCY cycles after the grant cycle, with rdata=ram_dout.
REQ-022 SHALL not delay or reorder reads behind writes; a write to an address with a read in flight does not affect that read.

Reset
REQ-023 SHALL on rst=0 at a clock edge: clear the tag pipeline (in-flight reads dropped, no rvalid), set the last-granted pointer to 1 (requester 0 wins first tie), clear the init counter, and enter INIT (macro defined) or SERVE (undefined).
REQ-024 SHALL hold gnt=0, rvalid=0 and all RAM enables at 0 while rst=0.

Configuration
REQ-025 SHALL with RAM_ARBITER_INIT_EN defined: in INIT write 0 to addresses 0..MEM_DEPTH-1, one per cycle (blk_select=1, wr_en=1), then enter SERVE the cycle after writing MEM_DEPTH-1; busy is high for exactly MEM_DEPTH cycles after reset release.
REQ-026 SHALL without RAM_ARBITER_INIT_EN: omit the INIT sweep and counter; busy is constant 0 and SERVE is entered directly from reset.

Structure
REQ-027 SHALL place the state enum (INIT, SERVE) and a requester-id typedef in shared package ram_pkg.
REQ-028 SHALL implement the tag shift register as sub-module rd_tag_pipe (parameter RD_LATENCY).

Verification
REQ-029 SHALL cover: INIT_EN defined, reset release -> busy high 1024 cycles, addresses 0..1023 written 0, then busy=0.
REQ-030 SHALL cover: req0 write addr 5 data 0xA5A5, then req1 read addr 5 -> rvalid[1] two cycles after grant with rdata=0xA5A5.
REQ-031 SHALL cover: both requesters reading every cycle for 8 cycles -> gnt alternates 01,10,01...; rvalid ids match grant order.
REQ-032 SHALL cover: rst=0 one cycle after a read grant -> no rvalid for that read; first tie after reset goes to requester 0.
REQ-033 SHALL cover: read addr 7 then write addr 7 (0x1234) next cycle, prior content 0x0F0F -> read returns 0x0F0F.
REQ-034 SHALL cover: RD_LATENCY=1 build -> rvalid one cycle after grant.
